phy_rx_serial_paralelo: RTL and testbench

- Receive-side deserializer that sits directly downstream of phy_tx.
- Consumes the 1-bit serial stream phy_tx emits (MSB first, idle filled with comma 8'hBC).
- Finds byte alignment from commas and declares the link active after LOCK_COUNT consecutive aligned commas.
- From then on delivers parallel bytes with a valid flag to the RX lane-unstriping logic.

---
 rtl/phy_pkg.sv | 21 ++
 rtl/phy_rx_shift8.sv | 31 +++
 rtl/phy_rx_serial_paralelo.sv | 143 ++++++++++++++
 tb/tb_phy_rx_serial_paralelo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared definitions for the PHY serial link (phy_tx and phy_rx_serial_paralelo).
// Holds the comma symbol, the receiver state encoding and the default
// lock / loss-of-sync counts.
package phy_pkg;

   localparam logic [7:0] COMMA_BC       = 8'hBC;
   localparam int         LOCK_COUNT_DEF = 4;
   localparam int         LOS_COUNT_DEF  = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      LOCK   = 2'd1,
      ACTIVE = 2'd2
   } rx_state_t;

   // Byte seen on this edge: the current shift register advanced by one bit.
   function automatic logic [7:0] next_window(input logic [7:0] sr, input logic bit_in);
      return {sr[6:0], bit_in};
   endfunction

endpackage

// File: rtl/phy_rx_shift8.sv
// 8-bit serial shift register with a wrapping 0..7 bit counter.
// realign restarts the counter so a boundary falls 8 bits after that edge.
module phy_rx_shift8
   import phy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       data_in,
   input  logic       realign,
   output logic [7:0] window,
   output logic       boundary
);

   logic [7:0] sr;
   logic [2:0] bit_cnt;

   assign window   = next_window(sr, data_in);
   assign boundary = (bit_cnt == 3'd7);

   // Shift in one bit per edge; counter wraps naturally at 7.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr      <= 8'h00;
         bit_cnt <= 3'd0;
      end else begin
         sr      <= window;
         bit_cnt <= realign ? 3'd0 : bit_cnt + 3'd1;
      end
   end

endmodule

// File: rtl/phy_rx_serial_paralelo.sv
// Receive deserializer: finds byte alignment from commas, locks after
// LOCK_COUNT aligned commas, then emits parallel bytes with a valid flag.
// Optional feature macro RX_LOS_EN: loss-of-sync after LOS_COUNT misaligned
// commas while active; without it ACTIVE is left only through reset.
module phy_rx_serial_paralelo
   import phy_pkg::*;
#(
   parameter logic [7:0] COMMA      = COMMA_BC,
   parameter int         LOCK_COUNT = LOCK_COUNT_DEF
`ifdef RX_LOS_EN
   ,
   parameter int         LOS_COUNT  = LOS_COUNT_DEF
`endif
)(
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   localparam int BCW = $clog2(LOCK_COUNT + 1);
   localparam logic [BCW-1:0] BC_ONE  = BCW'(1);
   localparam logic [BCW-1:0] BC_LOCK = BCW'(LOCK_COUNT);

   rx_state_t      state, state_nxt;
   logic [BCW-1:0] bc_cnt, bc_nxt, bc_inc;
   logic [7:0]     data_nxt;
   logic           valid_nxt;
   logic [7:0]     window;
   logic           boundary;
   logic           realign;
   logic           is_comma;

`ifdef RX_LOS_EN
   localparam int MCW = $clog2(LOS_COUNT + 1);
   localparam logic [MCW-1:0] MIS_ONE  = MCW'(1);
   localparam logic [MCW-1:0] MIS_LAST = MCW'(LOS_COUNT - 1);
   logic [MCW-1:0] mis_cnt, mis_nxt;
`endif

   phy_rx_shift8 u_shift (
      .clk      (clk_32f),
      .reset    (reset),
      .data_in  (data_in),
      .realign  (realign),
      .window   (window),
      .boundary (boundary)
   );

   assign is_comma = (window == COMMA);
   assign active   = (state == ACTIVE);
   // Saturating increment of the aligned-comma count.
   assign bc_inc   = (bc_cnt == BC_LOCK) ? bc_cnt : bc_cnt + BC_ONE;

   // State, lock counter and output byte registers.
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state     <= SEARCH;
         bc_cnt    <= '0;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
`ifdef RX_LOS_EN
         mis_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         bc_cnt    <= bc_nxt;
         data_out  <= data_nxt;
         valid_out <= valid_nxt;
`ifdef RX_LOS_EN
         mis_cnt   <= mis_nxt;
`endif
      end
   end

   // Alignment search, lock qualification and byte delivery.
   always_comb begin
      state_nxt = state;
      bc_nxt    = bc_cnt;
      data_nxt  = data_out;
      valid_nxt = valid_out;
      realign   = 1'b0;
`ifdef RX_LOS_EN
      mis_nxt   = mis_cnt;
`endif
      unique case (state)
         SEARCH: begin
            if (is_comma) begin
               realign = 1'b1;
               bc_nxt  = BC_ONE;
               if (LOCK_COUNT == 1) begin
                  state_nxt = ACTIVE;
                  data_nxt  = window;
                  valid_nxt = 1'b0;
               end else begin
                  state_nxt = LOCK;
               end
            end
         end
         LOCK: begin
            if (boundary) begin
               if (is_comma) begin
                  bc_nxt = bc_inc;
                  if (bc_inc == BC_LOCK) begin
                     state_nxt = ACTIVE;
                     data_nxt  = window;
                     valid_nxt = 1'b0;
                  end
               end else begin
                  bc_nxt    = '0;
                  state_nxt = SEARCH;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               data_nxt  = window;
               valid_nxt = !is_comma;
`ifdef RX_LOS_EN
               if (is_comma) mis_nxt = '0;
`endif
            end
`ifdef RX_LOS_EN
            else if (is_comma) begin
               // A comma off the byte grid means alignment has slipped.
               if (mis_cnt == MIS_LAST) begin
                  state_nxt = SEARCH;
                  data_nxt  = 8'h00;
                  valid_nxt = 1'b0;
                  mis_nxt   = '0;
               end else begin
                  mis_nxt = mis_cnt + MIS_ONE;
               end
            end
`endif
         end
         default: state_nxt = SEARCH;
      endcase
   end

endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Self-checking bench for phy_rx_serial_paralelo: directed scenarios plus
// randomized payload, checked edge by edge against a stream-level model.
module tb_phy_rx_serial_paralelo;
   import phy_pkg::*;

   localparam int LOCKN = LOCK_COUNT_DEF;
   localparam int LOSN  = LOS_COUNT_DEF;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b1;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int checks = 0;
   int passes = 0;

   phy_rx_serial_paralelo dut (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in   (data_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .active    (active)
   );

   always #5 clk_32f = ~clk_32f;

   // ---------------- reference model (stream positions, not counters) -----
   bit         hist[$];
   bit         stim[$];
   int         n;        // edges since reset release
   int         anchor;   // edge index of the aligning comma
   int         commas;
   int         misses;
   int         mode;     // 0 hunting, 1 qualifying, 2 delivering
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_active;

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(1'b0);
      n = 0; anchor = 0; commas = 0; misses = 0; mode = 0;
      m_data = 8'h00; m_valid = 1'b0; m_active = 1'b0;
   endtask

   task automatic model_step(input bit b);
      logic [7:0] w;
      bit         on_grid;
      hist.push_back(b);
      hist.pop_front();
      n++;
      for (int i = 0; i < 8; i++) w[7-i] = hist[i];
      on_grid = (n > anchor) && (((n - anchor) % 8) == 0);
      if (mode == 0) begin
         if (w == 8'hBC) begin
            anchor = n; commas = 1;
            if (LOCKN == 1) begin mode = 2; m_active = 1; m_data = w; m_valid = 0; end
            else mode = 1;
         end
      end else if (mode == 1) begin
         if (on_grid) begin
            if (w == 8'hBC) begin
               commas++;
               if (commas == LOCKN) begin mode = 2; m_active = 1; m_data = w; m_valid = 0; end
            end else begin
               mode = 0; commas = 0;
            end
         end
      end else begin
         if (on_grid) begin
            m_data  = w;
            m_valid = (w != 8'hBC);
            if (w == 8'hBC) misses = 0;
         end
`ifdef RX_LOS_EN
         else if (w == 8'hBC) begin
            misses++;
            if (misses == LOSN) begin
               mode = 0; m_active = 0; m_data = 8'h00; m_valid = 0; misses = 0;
            end
         end
`endif
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic add_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) stim.push_back(v[i]);
   endtask

   task automatic send_bit(input bit b);
      data_in = b;
      @(posedge clk_32f);
      #1;
      model_step(b);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      data_in = 1'b0;
      repeat (3) @(posedge clk_32f);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (data_out === 8'h00) passes++; else $display("FAIL reset_data got %h expected 00", data_out);
      checks++; if (valid_out === 1'b0) passes++; else $display("FAIL reset_valid got %b expected 0", valid_out);
      checks++; if (active === 1'b0) passes++; else $display("FAIL reset_active got %b expected 0", active);
      stim.delete();
      repeat (4) add_byte(8'hBC);
      add_byte(8'h45);
      for (int i = 0; i < 3; i++) stim.push_back(1'b1);
      foreach (stim[i]) send_bit(stim[i]);
      checks++;
      if ({data_out, valid_out, active} === {8'h45, 1'b1, 1'b1}) passes++;
      else $display("FAIL reset_prelock got %h/%b/%b expected 45/1/1", data_out, valid_out, active);
      // Mid-byte asynchronous reset must clear outputs before the next edge.
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({data_out, valid_out, active} === {8'h00, 1'b0, 1'b0}) passes++;
      else $display("FAIL reset_async got %h/%b/%b expected 00/0/0", data_out, valid_out, active);
      repeat (3) @(posedge clk_32f);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 12; i++) begin
         send_bit(1'($urandom_range(0, 1)));
         checks++;
         if ({data_out, valid_out, active} === {m_data, m_valid, m_active}) passes++;
         else $display("FAIL reset_after edge %0d got %h/%b/%b expected %h/%b/%b",
                       n, data_out, valid_out, active, m_data, m_valid, m_active);
      end
   endtask

   task automatic test_lock_offset();
      do_reset();
      stim.delete();
      stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
      repeat (4) add_byte(8'hBC);
      foreach (stim[i]) begin
         send_bit(stim[i]);
         checks++;
         if ({data_out, valid_out, active} === {m_data, m_valid, m_active}) passes++;
         else $display("FAIL lock_model edge %0d got %h/%b/%b expected %h/%b/%b",
                       n, data_out, valid_out, active, m_data, m_valid, m_active);
         if (n == 34) begin
            checks++; if (active === 1'b0) passes++; else $display("FAIL lock_early edge 34 active %b expected 0", active);
         end
         if (n == 35) begin
            checks++;
            if ({data_out, valid_out, active} === {8'hBC, 1'b0, 1'b1}) passes++;
            else $display("FAIL lock_edge35 got %h/%b/%b expected BC/0/1", data_out, valid_out, active);
         end
      end
   endtask

   task automatic test_broken_lock();
      do_reset();
      stim.delete();
      repeat (3) add_byte(8'hBC);
      add_byte(8'h5A);
      repeat (4) add_byte(8'hBC);
      foreach (stim[i]) begin
         send_bit(stim[i]);
         checks++;
         if ({data_out, valid_out, active} === {m_data, m_valid, m_active}) passes++;
         else $display("FAIL broken_model edge %0d got %h/%b/%b expected %h/%b/%b",
                       n, data_out, valid_out, active, m_data, m_valid, m_active);
         if (n < 64) begin
            checks++; if (active === 1'b0) passes++; else $display("FAIL broken_early edge %0d active %b expected 0", n, active);
         end else begin
            checks++; if (active === 1'b1) passes++; else $display("FAIL broken_relock edge %0d active %b expected 1", n, active);
         end
      end
   endtask

   task automatic test_payload();
      logic [7:0] exp_b [4] = '{8'hBC, 8'h45, 8'hBC, 8'hFF};
      int k;
      do_reset();
      stim.delete();
      repeat (4) add_byte(8'hBC);
      foreach (exp_b[i]) add_byte(exp_b[i]);
      foreach (stim[i]) begin
         send_bit(stim[i]);
         checks++;
         if ({data_out, valid_out, active} === {m_data, m_valid, m_active}) passes++;
         else $display("FAIL payload_model edge %0d got %h/%b/%b expected %h/%b/%b",
                       n, data_out, valid_out, active, m_data, m_valid, m_active);
         if (n >= 40) begin
            k = (n - 40) / 8;
            checks++;
            if (data_out === exp_b[k] && valid_out === (exp_b[k] != 8'hBC)) passes++;
            else $display("FAIL payload_byte%0d edge %0d got %h/%b expected %h/%b",
                          k, n, data_out, valid_out, exp_b[k], exp_b[k] != 8'hBC);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] want;
      do_reset();
      stim.delete();
      repeat (4) add_byte(8'hBC);
      for (int b = 0; b < 20; b++) add_byte(8'(b));
      foreach (stim[i]) begin
         send_bit(stim[i]);
         checks++;
         if ({data_out, valid_out, active} === {m_data, m_valid, m_active}) passes++;
         else $display("FAIL wrap_model edge %0d got %h/%b/%b expected %h/%b/%b",
                       n, data_out, valid_out, active, m_data, m_valid, m_active);
         if (n >= 40) begin
            want = 8'((n - 40) / 8);
            checks++;
            if (data_out === want && valid_out === 1'b1) passes++;
            else $display("FAIL wrap_byte edge %0d got %h/%b expected %h/1", n, data_out, valid_out, want);
         end
      end
   endtask

   task automatic test_los();
      int shift_end;
      do_reset();
      stim.delete();
      repeat (4) add_byte(8'hBC);
      add_byte(8'h00);
      for (int i = 0; i < 3; i++) stim.push_back(1'b0);
      repeat (4) add_byte(8'hBC);   // misaligned by 3 bits
      repeat (4) add_byte(8'hBC);   // realign on the new grid
      shift_end = 40 + 3 + 32;       // edge of the 4th misaligned comma
      foreach (stim[i]) begin
         send_bit(stim[i]);
         checks++;
         if ({data_out, valid_out, active} === {m_data, m_valid, m_active}) passes++;
         else $display("FAIL los_model edge %0d got %h/%b/%b expected %h/%b/%b",
                       n, data_out, valid_out, active, m_data, m_valid, m_active);
         if (n == shift_end - 1) begin
            checks++; if (active === 1'b1) passes++; else $display("FAIL los_before active %b expected 1", active);
         end
         if (n == shift_end) begin
`ifdef RX_LOS_EN
            checks++;
            if ({data_out, valid_out, active} === {8'h00, 1'b0, 1'b0}) passes++;
            else $display("FAIL los_drop got %h/%b/%b expected 00/0/0", data_out, valid_out, active);
`else
            checks++; if (active === 1'b1) passes++; else $display("FAIL los_sticky active %b expected 1", active);
`endif
         end
      end
      checks++; if (active === 1'b1) passes++; else $display("FAIL los_relock active %b expected 1", active);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         do_reset();
         stim.delete();
         for (int i = 0, len = $urandom_range(0, 7); i < len; i++) stim.push_back(1'($urandom_range(0, 1)));
         repeat (4) add_byte(8'hBC);
         for (int b = 0; b < 40; b++) add_byte(($urandom_range(0, 5) == 0) ? 8'hBC : 8'($urandom));
         foreach (stim[i]) begin
            send_bit(stim[i]);
            checks++;
            if ({data_out, valid_out, active} === {m_data, m_valid, m_active}) passes++;
            else $display("FAIL random%0d edge %0d got %h/%b/%b expected %h/%b/%b",
                          r, n, data_out, valid_out, active, m_data, m_valid, m_active);
         end
         checks++; if (active === 1'b1) passes++; else $display("FAIL random%0d_active got %b expected 1", r, active);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock_offset();
      test_broken_lock();
      test_payload();
      test_wrap();
      test_los();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
